reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised, reset-clearable register file for the multi-cycle pipelined RISC-V core. It provides NUM_RD combinational read ports with write-to-read bypass and one synchronous write port. It also contains an integrated per-register busy scoreboard that tracks in-flight destination registers between issue and writeback. It sits between decode/issue (reads, issue marks) and writeback (writes, busy clears).

## Interface
- DEPTH, 32, number of architectural registers
- WIDTH, 32, register data width in bits
- ADD_WIDTH, 5, register address width; must satisfy 2**ADD_WIDTH >= DEPTH
- NUM_RD, 2, number of read ports (1..4)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- w_en  input  1  writeback enable
- w_reg  input  ADD_WIDTH  writeback destination
- w_data  input  WIDTH  writeback data
- issue_en  input  1  an instruction with a destination is issuing this cycle
- issue_reg  input  ADD_WIDTH  destination of the issuing instruction
- r_reg  input  NUM_RD*ADD_WIDTH  read addresses, port k at bits [k*ADD_WIDTH +: ADD_WIDTH]
- read_data  output  NUM_RD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH]
- r_busy  output  NUM_RD  port k's source register has an outstanding producer
- busy_cnt  output  ADD_WIDTH+1  number of registers currently marked busy

## Operation
- Reset (rst_n low, any time, asynchronous):
  - all registers are 0 and all busy bits are 0.
  - busy_cnt = 0, read_data = 0, r_busy = 0.
  - This holds mid-write and mid-issue; pending operations are discarded.
- Register 0:
  - hardwired zero; writes to it are ignored.
  - it is never marked busy; issue to it is ignored.
  - reads of it return 0 even during bypass.
- Write: if w_en and w_reg != 0 and w_reg < DEPTH, registers[w_reg] <= w_data on the rising edge.
- Read port k (combinational):
  - if w_en and w_reg == r_reg[k] and r_reg[k] != 0, returns w_data (bypass).
  - otherwise returns registers[r_reg[k]].
  - an address >= DEPTH returns 0.
- Scoreboard (busy[i] updated at posedge):
  - busy[w_reg] is cleared when w_en is asserted.
  - busy[issue_reg] is set when issue_en is asserted.
  - issue and write to the same register in the same cycle: set wins, because the new producer supersedes the old one.
- r_busy[k] = busy[r_reg[k]] & ~(w_en & w_reg == r_reg[k]).
  - This reflects the pre-edge busy state, with the same-cycle writeback bypassed.
  - A same-cycle issue does not affect r_busy until the next cycle.
- Writeback to a register that is not busy: data is written and busy stays 0. This is legal and is not flagged.
- Issue to a register that is already busy: the bit stays 1 and busy_cnt is unchanged (WAW is allowed; the later writeback clears it).
- busy_cnt:
  - tracks the popcount of busy and is maintained incrementally: +1 on a 0→1 set, −1 on a 1→0 clear, net 0 when both or neither apply.
  - it must always equal the popcount of busy.

## Timing
- Read latency is 0 cycles, combinational from r_reg, w_en, w_reg and w_data.
- Write latency: data is committed at the next rising edge and is visible via bypass in the same cycle.
- Busy set: visible on r_busy in the cycle after issue_en.
- Busy clear: r_busy drops combinationally in the writeback cycle; the stored bit clears at the edge.
- busy_cnt is registered and updates at the edge.

## Structure
- Package reg_file_pkg holds:
  - default DEPTH, WIDTH and ADD_WIDTH;
  - the REG_ZERO address constant;
  - a function for extracting port slices from the flattened buses.
- Sub-module reg_file_scoreboard holds the busy vector and busy_cnt (inputs: issue, writeback, read addresses). The top level holds the storage array, the read muxes and the bypass.

## Test plan
- Reset clearing:
  - write 0xDEADBEEF to x5, issue x7, then pulse rst_n low mid-cycle.
  - Required: read x5 = 0, r_busy = 0 and busy_cnt = 0 immediately, without waiting for a clock edge.
- Write/bypass:
  - w_en=1, w_reg=3, w_data=0x1234_5678 with r_reg port0=3.
  - Required: read_data port0 = 0x12345678 in the same cycle, and still 0x12345678 after the edge with w_en=0.
- x0 protection:
  - write 0xFFFF_FFFF to x0 and issue x0; read x0 on all ports.
  - Required: data = 0, r_busy = 0, busy_cnt = 0.
- Scoreboard lifecycle:
  - issue x10 at cycle 0.
  - Required: cycle 1 r_busy (port x10) = 1 and busy_cnt = 1.
  - Then writeback x10=0xA5 at cycle 3.
  - Required: r_busy = 0 and data = 0xA5 in cycle 3, busy_cnt = 0 in cycle 4.
- Simultaneous issue + writeback of x12:
  - Required: busy[x12] remains 1 and busy_cnt is unchanged.
  - Issue of x13 together with writeback of x12 (which was busy): busy_cnt net unchanged, x13 busy, x12 clear.
- Parameter sweep:
  - NUM_RD=4, DEPTH=16, ADD_WIDTH=5 with random issue/write traffic over 10k cycles.
  - Required: read_data matches a reference model, busy_cnt equals the popcount every cycle, and reads of x16..x31 return 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults, constants and bus-slicing helper for the register file and its scoreboard.
package reg_file_pkg;

    localparam int unsigned DEFAULT_DEPTH     = 32;
    localparam int unsigned DEFAULT_WIDTH     = 32;
    localparam int unsigned DEFAULT_ADD_WIDTH = 5;

    // Architectural zero register.
    localparam int unsigned REG_ZERO = 0;

    // Widest flattened bus the slice helper handles (4 ports x 64 bits).
    localparam int unsigned BUS_MAX = 256;

    // Returns port 'port' of a flattened bus whose slices are 'width' bits wide, zero-extended.
    function automatic logic [BUS_MAX-1:0] port_slice(input logic [BUS_MAX-1:0] bus,
                                                      input int unsigned        port,
                                                      input int unsigned        width);
        logic [BUS_MAX-1:0] mask;
        mask = {BUS_MAX{1'b1}} >> (BUS_MAX - width);
        return (bus >> (port * width)) & mask;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy tracker: set on issue, cleared on writeback, with a running busy count.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned ADD_WIDTH = DEFAULT_ADD_WIDTH,
    parameter int unsigned NUM_RD    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_en,
    input  logic [ADD_WIDTH-1:0]        w_reg,
    input  logic                        issue_en,
    input  logic [ADD_WIDTH-1:0]        issue_reg,
    input  logic [NUM_RD*ADD_WIDTH-1:0] r_reg,
    output logic [NUM_RD-1:0]           r_busy,
    output logic [ADD_WIDTH:0]          busy_cnt
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = ADD_WIDTH + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_ok, clr_ok, set_new, clr_real;
    logic [IDX_W-1:0] w_idx, i_idx;

    assign w_idx  = w_reg[IDX_W-1:0];
    assign i_idx  = issue_reg[IDX_W-1:0];
    assign clr_ok = w_en && (32'(w_reg) < DEPTH);
    assign set_ok = issue_en && (32'(issue_reg) != REG_ZERO) && (32'(issue_reg) < DEPTH);

    // Next busy vector and count; a same-register set overrides the clear.
    always_comb begin
        busy_d   = busy_q;
        set_new  = set_ok && !busy_q[i_idx];
        clr_real = clr_ok && busy_q[w_idx] && !(set_ok && (i_idx == w_idx));
        if (clr_ok) busy_d[w_idx] = 1'b0;
        if (set_ok) busy_d[i_idx] = 1'b1;
        cnt_d = cnt_q + CNT_W'(set_new) - CNT_W'(clr_real);
    end

    // Busy state and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // Pre-edge busy per read port, with a same-cycle writeback bypassed away.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rbusy
        logic [ADD_WIDTH-1:0] addr;
        assign addr = ADD_WIDTH'(port_slice(BUS_MAX'(r_reg), k, ADD_WIDTH));
        assign r_busy[k] = (32'(addr) < DEPTH) && busy_q[addr[IDX_W-1:0]] &&
                           !(w_en && (w_reg == addr));
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with zero-latency bypassed reads, one write port and an integrated scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned ADD_WIDTH = DEFAULT_ADD_WIDTH,
    parameter int unsigned NUM_RD    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_en,
    input  logic [ADD_WIDTH-1:0]        w_reg,
    input  logic [WIDTH-1:0]            w_data,
    input  logic                        issue_en,
    input  logic [ADD_WIDTH-1:0]        issue_reg,
    input  logic [NUM_RD*ADD_WIDTH-1:0] r_reg,
    output logic [NUM_RD*WIDTH-1:0]     read_data,
    output logic [NUM_RD-1:0]           r_busy,
    output logic [ADD_WIDTH:0]          busy_cnt
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     regs [DEPTH];
    logic                 wr_ok;
    logic [ADD_WIDTH-1:0] rd_addr [NUM_RD];

    assign wr_ok = w_en && (32'(w_reg) != REG_ZERO) && (32'(w_reg) < DEPTH);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_addr
        assign rd_addr[k] = ADD_WIDTH'(port_slice(BUS_MAX'(r_reg), k, ADD_WIDTH));
    end

    // Storage: x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (wr_ok) begin
            regs[w_reg[IDX_W-1:0]] <= w_data;
        end
    end

    // Read muxes: zero for x0, out-of-range or reset; otherwise bypass, then array.
    always_comb begin
        read_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!rst_n || (32'(rd_addr[k]) == REG_ZERO) || (32'(rd_addr[k]) >= DEPTH)) begin
                read_data[k*WIDTH +: WIDTH] = '0;
            end else if (w_en && (w_reg == rd_addr[k])) begin
                read_data[k*WIDTH +: WIDTH] = w_data;
            end else begin
                read_data[k*WIDTH +: WIDTH] = regs[rd_addr[k][IDX_W-1:0]];
            end
        end
    end

    reg_file_scoreboard #(
        .DEPTH     (DEPTH),
        .ADD_WIDTH (ADD_WIDTH),
        .NUM_RD    (NUM_RD)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_en      (w_en),
        .w_reg     (w_reg),
        .issue_en  (issue_en),
        .issue_reg (issue_reg),
        .r_reg     (r_reg),
        .r_busy    (r_busy),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vectors with literal expectations plus a per-cycle model check.
module tb_reg_file_sb;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ADD_WIDTH = 5;
    localparam int unsigned NUM_RD    = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        w_en;
    logic [ADD_WIDTH-1:0]        w_reg;
    logic [WIDTH-1:0]            w_data;
    logic                        issue_en;
    logic [ADD_WIDTH-1:0]        issue_reg;
    logic [NUM_RD*ADD_WIDTH-1:0] r_reg;
    logic [NUM_RD*WIDTH-1:0]     read_data;
    logic [NUM_RD-1:0]           r_busy;
    logic [ADD_WIDTH:0]          busy_cnt;

    logic [ADD_WIDTH-1:0] rp [NUM_RD];
    assign r_reg = {rp[3], rp[2], rp[1], rp[0]};

    reg_file_sb #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .ADD_WIDTH (ADD_WIDTH),
        .NUM_RD    (NUM_RD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_en      (w_en),
        .w_reg     (w_reg),
        .w_data    (w_data),
        .issue_en  (issue_en),
        .issue_reg (issue_reg),
        .r_reg     (r_reg),
        .read_data (read_data),
        .r_busy    (r_busy),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model: 32 addressable slots, only 1..DEPTH-1 ever hold data or busy.
    logic [WIDTH-1:0] m_regs [32];
    bit               m_busy [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rdp(input int k);
        return read_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Expected outputs from the current inputs and architectural state.
    task automatic model_check();
        int               pop;
        logic [WIDTH-1:0] exp_d;
        bit               exp_b;
        int               a;
        pop = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) pop++;
        for (int k = 0; k < NUM_RD; k++) begin
            a = int'(rp[k]);
            if (a == 0 || a >= DEPTH) exp_d = '0;
            else if (w_en && int'(w_reg) == a) exp_d = w_data;
            else exp_d = m_regs[a];
            exp_b = (a < DEPTH) && m_busy[a] && !(w_en && int'(w_reg) == a);
            check($sformatf("model read_data[%0d] x%0d", k, a), 64'(rdp(k)), 64'(exp_d));
            check($sformatf("model r_busy[%0d] x%0d", k, a), 64'(r_busy[k]), 64'(exp_b));
        end
        check("model busy_cnt", 64'(busy_cnt), 64'(pop));
    endtask

    task automatic model_update();
        if (w_en && int'(w_reg) < DEPTH) begin
            if (w_reg != 0) m_regs[w_reg] = w_data;
            m_busy[w_reg] = 1'b0;
        end
        if (issue_en && issue_reg != 0 && int'(issue_reg) < DEPTH) m_busy[issue_reg] = 1'b1;
    endtask

    // Apply one cycle of inputs (called just after a rising edge) and check combinational outputs.
    task automatic drive(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                         input bit ie, input logic [4:0] ir,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] r3);
        w_en = we; w_reg = wr; w_data = wd;
        issue_en = ie; issue_reg = ir;
        rp[0] = r0; rp[1] = r1; rp[2] = r2; rp[3] = r3;
        #2;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        w_en = 1'b0; w_reg = '0; w_data = '0; issue_en = 1'b0; issue_reg = '0;
        for (int k = 0; k < NUM_RD; k++) rp[k] = '0;
        model_reset();
        #2;
        check("reset read_data", 64'(read_data[63:0]), 64'd0);
        check("reset r_busy", 64'(r_busy), 64'd0);
        check("reset busy_cnt", 64'(busy_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write with same-cycle bypass, then registered read.
        drive(1, 3, 32'h1234_5678, 0, 0, 3, 0, 0, 0);
        check("bypass x3", 64'(rdp(0)), 64'h1234_5678);
        tick();
        drive(0, 0, 0, 0, 0, 3, 3, 0, 0);
        check("stored x3", 64'(rdp(0)), 64'h1234_5678);
        tick();

        // x0 is hardwired: write and issue to it are ignored.
        drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
        check("x0 bypass", 64'(read_data), 64'd0);
        check("x0 r_busy", 64'(r_busy), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x0 data", 64'(read_data[127:64]), 64'd0);
        check("x0 busy_cnt", 64'(busy_cnt), 64'd0);
        tick();

        // Scoreboard lifecycle of x10.
        drive(0, 0, 0, 1, 10, 10, 0, 0, 0);
        check("c0 r_busy x10", 64'(r_busy[0]), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 10, 0, 0, 0);
        check("c1 r_busy x10", 64'(r_busy[0]), 64'd1);
        check("c1 busy_cnt", 64'(busy_cnt), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 10, 0, 0, 0);
        tick();
        drive(1, 10, 32'hA5, 0, 0, 10, 0, 0, 0);
        check("c3 r_busy x10", 64'(r_busy[0]), 64'd0);
        check("c3 data x10", 64'(rdp(0)), 64'hA5);
        tick();
        drive(0, 0, 0, 0, 0, 10, 0, 0, 0);
        check("c4 busy_cnt", 64'(busy_cnt), 64'd0);
        tick();

        // Simultaneous issue and writeback.
        drive(0, 0, 0, 1, 12, 12, 0, 0, 0);
        tick();
        drive(1, 12, 32'h77, 1, 12, 12, 0, 0, 0);
        check("same-reg bypass r_busy", 64'(r_busy[0]), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 12, 0, 0, 0);
        check("same-reg still busy", 64'(r_busy[0]), 64'd1);
        check("same-reg busy_cnt", 64'(busy_cnt), 64'd1);
        check("same-reg data", 64'(rdp(0)), 64'h77);
        tick();
        drive(1, 12, 32'h88, 1, 13, 12, 13, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 12, 13, 0, 0);
        check("x12 cleared", 64'(r_busy[0]), 64'd0);
        check("x13 set", 64'(r_busy[1]), 64'd1);
        check("swap busy_cnt", 64'(busy_cnt), 64'd1);
        check("x12 data", 64'(rdp(0)), 64'h88);
        tick();
        // WAW on x13 leaves the count alone.
        drive(0, 0, 0, 1, 13, 13, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 13, 0, 0, 0);
        check("waw busy_cnt", 64'(busy_cnt), 64'd1);
        tick();

        // Out-of-range addresses read zero; writes and issues there are dropped.
        drive(1, 20, 32'h55, 1, 17, 20, 31, 16, 17);
        check("oor bypass x20", 64'(rdp(0)), 64'd0);
        check("oor r_busy", 64'(r_busy), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 20, 31, 16, 17);
        check("oor x31", 64'(rdp(1)), 64'd0);
        check("oor busy_cnt", 64'(busy_cnt), 64'd1);
        tick();

        // Writeback to a non-busy register.
        drive(1, 4, 32'h44, 0, 0, 4, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 4, 0, 0, 0);
        check("non-busy wb data", 64'(rdp(0)), 64'h44);
        check("non-busy wb busy_cnt", 64'(busy_cnt), 64'd1);
        tick();

        // Asynchronous reset in mid-cycle with a write and an issue pending.
        drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 7, 5, 7, 0, 0);
        tick();
        drive(1, 5, 32'hCAFE_0001, 1, 9, 5, 7, 0, 0);
        check("pre-reset busy_cnt", 64'(busy_cnt), 64'd2);
        check("pre-reset r_busy x7", 64'(r_busy[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async reset x5", 64'(rdp(0)), 64'd0);
        check("async reset r_busy", 64'(r_busy), 64'd0);
        check("async reset busy_cnt", 64'(busy_cnt), 64'd0);
        model_reset();
        w_en = 1'b0; issue_en = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check("post-reset x5", 64'(rdp(0)), 64'd0);
        drive(0, 0, 0, 0, 0, 5, 7, 9, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5, 7, 9, 0);
        check("post-reset busy_cnt", 64'(busy_cnt), 64'd0);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
